// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller state encoding, address-field widths and byte selection.
package dcache_controller_pkg;

  localparam int OFFSET_BITS    = 2;
  localparam int INDEX_BITS     = 3;
  localparam int TAG_BITS       = 6 - INDEX_BITS;
  localparam int BLOCK_BITS     = 32;
  localparam int MEM_ADDR_BITS  = 6;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2,
    UPDATE     = 2'd3
  } cache_state_e;

  // Offset n selects block[8n+7:8n].
  function automatic logic [7:0] select_byte(input logic [BLOCK_BITS-1:0] block,
                                             input logic [OFFSET_BITS-1:0] offset);
    logic [7:0] result;
    case (offset)
      2'd0:    result = block[7:0];
      2'd1:    result = block[15:8];
      2'd2:    result = block[23:16];
      default: result = block[31:24];
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Per-line valid/dirty/tag/data storage with async clear, one indexed read
// port, a CPU byte-write port and a memory block-fill port.
module dcache_line_array
  import dcache_controller_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 6 - INDEX_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_BITS-1:0]  index,
  output logic                   line_valid,
  output logic                   line_dirty,
  output logic [TAG_BITS-1:0]    line_tag,
  output logic [BLOCK_BITS-1:0]  line_data,
  input  logic                   byte_we,
  input  logic [OFFSET_BITS-1:0] byte_offset,
  input  logic [7:0]             byte_data,
  input  logic                   fill_we,
  input  logic [TAG_BITS-1:0]    fill_tag,
  input  logic [BLOCK_BITS-1:0]  fill_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]                 valid_vec;
  logic [LINES-1:0]                 dirty_vec;
  logic [LINES-1:0][TAG_BITS-1:0]   tag_vec;
  logic [LINES-1:0][BLOCK_BITS-1:0] data_vec;

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic                  valid_reg;
      logic                  dirty_reg;
      logic [TAG_BITS-1:0]   tag_reg;
      logic [BLOCK_BITS-1:0] data_reg;
      logic                  line_sel;

      assign line_sel = (index == INDEX_BITS'(gi));

      // A fill always wins: it only happens in UPDATE, when no byte write is issued.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          dirty_reg <= 1'b0;
          tag_reg   <= '0;
          data_reg  <= '0;
        end else if (fill_we && line_sel) begin
          valid_reg <= 1'b1;
          dirty_reg <= 1'b0;
          tag_reg   <= fill_tag;
          data_reg  <= fill_data;
        end else if (byte_we && line_sel) begin
          dirty_reg <= 1'b1;
          for (int b = 0; b < BLOCK_BITS / 8; b++) begin
            if (byte_offset == OFFSET_BITS'(b)) begin
              data_reg[8*b +: 8] <= byte_data;
            end
          end
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign dirty_vec[gi] = dirty_reg;
      assign tag_vec[gi]   = tag_reg;
      assign data_vec[gi]  = data_reg;
    end
  endgenerate

  assign line_valid = valid_vec[index];
  assign line_dirty = dirty_vec[index];
  assign line_tag   = tag_vec[index];
  assign line_data  = data_vec[index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache: zero-stall hits,
// miss FSM sequencing victim write-back then block fetch.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int INDEX_BITS = dcache_controller_pkg::INDEX_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int TAG_BITS = 6 - INDEX_BITS;

  cache_state_e state_reg, state_next;

  logic [TAG_BITS-1:0]    addr_tag;
  logic [INDEX_BITS-1:0]  addr_index;
  logic [OFFSET_BITS-1:0] addr_offset;

  logic                  line_valid;
  logic                  line_dirty;
  logic [TAG_BITS-1:0]   line_tag;
  logic [BLOCK_BITS-1:0] line_data;

  logic request;
  logic hit;
  logic byte_we;
  logic fill_we;

  assign addr_tag    = address[7 -: TAG_BITS];
  assign addr_index  = address[OFFSET_BITS +: INDEX_BITS];
  assign addr_offset = address[OFFSET_BITS-1:0];

  assign request = read | write;
  assign hit     = line_valid && (line_tag == addr_tag);

  dcache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clock       (clock),
    .reset       (reset),
    .index       (addr_index),
    .line_valid  (line_valid),
    .line_dirty  (line_dirty),
    .line_tag    (line_tag),
    .line_data   (line_data),
    .byte_we     (byte_we),
    .byte_offset (addr_offset),
    .byte_data   (writedata),
    .fill_we     (fill_we),
    .fill_tag    (addr_tag),
    .fill_data   (mem_readdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Once a miss starts, the sequence runs to UPDATE regardless of the CPU request.
  always_comb begin
    state_next    = state_reg;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    byte_we       = 1'b0;
    fill_we       = 1'b0;
    busywait      = request && ((state_reg != IDLE) || !hit);

    case (state_reg)
      IDLE: begin
        if (request && !hit) begin
          state_next = (line_valid && line_dirty) ? WRITE_BACK : FETCH;
        end
        byte_we = write && hit;
      end
      WRITE_BACK: begin
        mem_write     = 1'b1;
        mem_address   = {line_tag, addr_index};
        mem_writedata = line_data;
        if (!mem_busywait) state_next = FETCH;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = {addr_tag, addr_index};
        if (!mem_busywait) state_next = UPDATE;
      end
      UPDATE: begin
        fill_we    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign readdata = (read && hit) ? select_byte(line_data, addr_offset) : 8'h00;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency block memory model.
module tb_dcache_controller;

  localparam int MEM_LAT = 3;  // cycles a request is held, busy for the first MEM_LAT-1
  localparam int MAX_STALL = 40;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks;
  int errors;

  dcache_controller #(.INDEX_BITS(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Block memory model
  logic [31:0] mem_array [64];
  int          mem_cnt;
  int          req_cycles;
  logic [31:0] mem_rdata_reg;

  assign mem_busywait = (mem_read | mem_write) && (mem_cnt != MEM_LAT - 1);
  assign mem_readdata = mem_rdata_reg;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_cnt       <= 0;
      req_cycles    <= 0;
      mem_rdata_reg <= 32'h0;
      for (int i = 0; i < 64; i++) mem_array[i] <= 32'h0;
      mem_array[6'h01] <= 32'h44332211;
      mem_array[6'h09] <= 32'h88776655;
      mem_array[6'h20] <= 32'hDDCCBBAA;
      mem_array[6'h28] <= 32'h12345678;
    end else if (mem_read || mem_write) begin
      req_cycles <= req_cycles + 1;
      if (mem_cnt == MEM_LAT - 1) begin
        mem_cnt <= 0;
        if (mem_write) mem_array[mem_address] <= mem_writedata;
        else           mem_rdata_reg <= mem_array[mem_address];
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Results of the last CPU access
  int          stall_cnt;
  logic [7:0]  got_rdata;
  logic        saw_wb;
  logic        saw_fetch;
  logic        order_ok;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic [5:0]  fetch_addr;

  // Called at a negedge; returns at a negedge with the request withdrawn.
  task automatic cpu_access(input logic rd, input logic wr,
                            input logic [7:0] addr, input logic [7:0] wdata);
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = wdata;
    stall_cnt = 0;
    saw_wb    = 1'b0;
    saw_fetch = 1'b0;
    order_ok  = 1'b1;
    wb_addr   = '0;
    wb_data   = '0;
    fetch_addr = '0;
    #1;
    while (busywait && stall_cnt < MAX_STALL) begin
      stall_cnt++;
      if (mem_write) begin
        saw_wb  = 1'b1;
        wb_addr = mem_address;
        wb_data = mem_writedata;
        if (saw_fetch) order_ok = 1'b0;
      end
      if (mem_read) begin
        saw_fetch  = 1'b1;
        fetch_addr = mem_address;
      end
      @(negedge clock);
      #1;
    end
    check_eq("busywait_released", {31'b0, busywait}, 32'd0);
    got_rdata = readdata;
    $display("access rd=%0b wr=%0b addr=%h wdata=%h stall=%0d rdata=%h wb=%0b wb_addr=%h wb_data=%h fetch=%0b fetch_addr=%h",
             rd, wr, addr, wdata, stall_cnt, got_rdata, saw_wb, wb_addr, wb_data, saw_fetch, fetch_addr);
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
  endtask

  int req_snapshot;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    address   = 8'h00;
    writedata = 8'h00;
    #1;
    check_eq("rst_busywait",      {31'b0, busywait},  32'd0);
    check_eq("rst_mem_read",      {31'b0, mem_read},  32'd0);
    check_eq("rst_mem_write",     {31'b0, mem_write}, 32'd0);
    check_eq("rst_mem_address",   {26'b0, mem_address}, 32'd0);
    check_eq("rst_mem_writedata", mem_writedata, 32'd0);
    check_eq("rst_readdata",      {24'b0, readdata},  32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Clean read miss on line 1
    cpu_access(1'b1, 1'b0, 8'h05, 8'h00);
    check_eq("miss05_stall",   stall_cnt, MEM_LAT + 2);
    check_eq("miss05_no_wb",   {31'b0, saw_wb}, 32'd0);
    check_eq("miss05_fetch",   {31'b0, saw_fetch}, 32'd1);
    check_eq("miss05_faddr",   {26'b0, fetch_addr}, 32'h01);
    check_eq("miss05_rdata",   {24'b0, got_rdata}, 32'h22);

    // Hits on the freshly filled line, no memory traffic
    req_snapshot = req_cycles;
    cpu_access(1'b1, 1'b0, 8'h07, 8'h00);
    check_eq("hit07_stall", stall_cnt, 0);
    check_eq("hit07_rdata", {24'b0, got_rdata}, 32'h44);
    cpu_access(1'b1, 1'b0, 8'h04, 8'h00);
    check_eq("hit04_stall", stall_cnt, 0);
    check_eq("hit04_rdata", {24'b0, got_rdata}, 32'h11);

    // Write hit then read back
    cpu_access(1'b0, 1'b1, 8'h06, 8'hAA);
    check_eq("whit06_stall", stall_cnt, 0);
    cpu_access(1'b1, 1'b0, 8'h06, 8'h00);
    check_eq("rd06_stall", stall_cnt, 0);
    check_eq("rd06_rdata", {24'b0, got_rdata}, 32'hAA);
    check_eq("hits_no_mem_req", req_cycles, req_snapshot);

    // Dirty conflict miss: write-back then fetch
    cpu_access(1'b1, 1'b0, 8'h25, 8'h00);
    check_eq("miss25_stall",  stall_cnt, 2 * MEM_LAT + 2);
    check_eq("miss25_wb",     {31'b0, saw_wb}, 32'd1);
    check_eq("miss25_wbaddr", {26'b0, wb_addr}, 32'h01);
    check_eq("miss25_wbdata", wb_data, 32'h44AA2211);
    check_eq("miss25_faddr",  {26'b0, fetch_addr}, 32'h09);
    check_eq("miss25_order",  {31'b0, order_ok}, 32'd1);
    check_eq("miss25_rdata",  {24'b0, got_rdata}, 32'h66);
    check_eq("mem01_written", mem_array[6'h01], 32'h44AA2211);

    // Write miss on a clean (invalid) line, then confirm byte and dirty bit
    cpu_access(1'b0, 1'b1, 8'h80, 8'h5C);
    check_eq("wmiss80_stall", stall_cnt, MEM_LAT + 2);
    check_eq("wmiss80_no_wb", {31'b0, saw_wb}, 32'd0);
    check_eq("wmiss80_faddr", {26'b0, fetch_addr}, 32'h20);
    cpu_access(1'b1, 1'b0, 8'h80, 8'h00);
    check_eq("rd80_stall", stall_cnt, 0);
    check_eq("rd80_rdata", {24'b0, got_rdata}, 32'h5C);
    cpu_access(1'b1, 1'b0, 8'hA0, 8'h00);
    check_eq("missA0_stall",  stall_cnt, 2 * MEM_LAT + 2);
    check_eq("missA0_wbaddr", {26'b0, wb_addr}, 32'h20);
    check_eq("missA0_wbdata", wb_data, 32'hDDCCBB5C);
    check_eq("missA0_faddr",  {26'b0, fetch_addr}, 32'h28);
    check_eq("missA0_rdata",  {24'b0, got_rdata}, 32'h78);

    // Reset in the middle of a fetch
    read    = 1'b1;
    address = 8'h05;
    @(negedge clock);
    @(negedge clock);
    #1;
    check_eq("midfetch_mem_read", {31'b0, mem_read}, 32'd1);
    reset = 1'b1;
    read  = 1'b0;
    #1;
    check_eq("rst_mid_mem_read", {31'b0, mem_read}, 32'd0);
    check_eq("rst_mid_busywait", {31'b0, busywait}, 32'd0);
    check_eq("rst_mid_mem_addr", {26'b0, mem_address}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    cpu_access(1'b1, 1'b0, 8'h05, 8'h00);
    check_eq("post_rst05_stall", stall_cnt, MEM_LAT + 2);
    check_eq("post_rst05_no_wb", {31'b0, saw_wb}, 32'd0);
    check_eq("post_rst05_rdata", {24'b0, got_rdata}, 32'h22);
    cpu_access(1'b1, 1'b0, 8'hA0, 8'h00);
    check_eq("post_rstA0_stall", stall_cnt, MEM_LAT + 2);
    check_eq("post_rstA0_no_wb", {31'b0, saw_wb}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU's byte interface and the 256x8 data memory, which is accessed as 4-byte blocks.
- Serves hits without stalling the CPU.
- On a miss it sequences the block memory: write-back of a dirty victim, then block fetch. It stalls the CPU through busywait until the access completes.

Parameters:
INDEX_BITS, 3, log2 of the number of cache lines (8 lines x 4 bytes); tag width = 6 - INDEX_BITS

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
read  in  1  CPU byte read request
write  in  1  CPU byte write request
address  in  8  CPU byte address: tag [7:2+INDEX_BITS], index [1+INDEX_BITS:2], offset [1:0]
writedata  in  8  CPU write byte
readdata  out  8  CPU read byte
busywait  out  1  CPU stall
mem_read  out  1  block memory read request
mem_write  out  1  block memory write request
mem_address  out  6  block address {tag,index}
mem_writedata  out  32  victim block, byte0 in [7:0]
mem_readdata  in  32  fetched block, byte0 in [7:0]
mem_busywait  in  1  block memory busy

Behaviour:
- Storage per line: data[31:0], tag, valid, dirty. Byte select: offset n maps to data[8n+7:8n].
- hit = valid[index] and tag[index] == address tag.
- Reset (asynchronous):
  - state=IDLE; all valid and dirty bits cleared; data and tags cleared.
  - Outputs: busywait=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, readdata=0.
  - Reset mid-miss abandons the memory transaction and discards dirty data.
- CPU contract: address, writedata, read and write are held stable while busywait=1. read and write together is illegal; the controller treats it as a write.
- busywait (combinational) = (read or write) and (state != IDLE or not hit). It rises in the same cycle as the request.
- readdata (combinational) = selected byte when read and hit, else 0.
- Read hit: zero-cycle latency, no stall.
- Write hit: byte written and dirty set at the posedge; busywait stays 0.
- States:
  - IDLE:
    - hit: no transition.
    - miss with line valid and dirty: go to WRITE_BACK.
    - miss otherwise: go to FETCH.
  - WRITE_BACK:
    - Outputs: mem_write=1, mem_address={stored tag,index}, mem_writedata=line data.
    - At the posedge where mem_busywait=0 (not the entry edge), go to FETCH.
  - FETCH:
    - Outputs: mem_read=1, mem_address={address tag,index}.
    - At the posedge where mem_busywait=0 (not the entry edge), go to UPDATE.
  - UPDATE:
    - Line data <= mem_readdata; tag <= address tag; valid=1; dirty=0.
    - mem_read and mem_write are low. Go to IDLE, where the access now hits and busywait falls.
- Memory handshake:
  - Each request is asserted from the state-entry edge and held until mem_busywait is sampled low at a posedge (not the entry edge).
  - Requests drop at the following edge; back-to-back requests always differ (write, then read).
- Miss penalty: clean miss = memory latency + 2 cycles; dirty miss = two memory latencies + 2 cycles.
- Write miss: the line is fetched first, then the write completes as a hit in IDLE and sets dirty.
- Request dropped while in WRITE_BACK/FETCH: the transaction still completes. Only busywait follows the request.

Decomposition:
- Shared package holds:
  - The state encoding (IDLE, WRITE_BACK, FETCH, UPDATE).
  - Address-field widths: TAG_BITS, INDEX_BITS, OFFSET_BITS=2.
  - Block width BLOCK_BITS=32.
- One natural sub-module, dcache_line_array: the valid/dirty/tag/data storage with async clear, indexed read port and two write ports (byte write, block fill). The FSM stays in dcache_controller.

Test Plan:
- Reset, then read 0x05: busywait=1, FETCH with mem_address=0x01, no write-back; after memory returns 0x44332211, busywait falls and readdata=0x22.
- After the fill, read 0x07 then 0x04: busywait stays 0; readdata=0x44, then 0x11; no memory request issued.
- Write 0xAA to 0x06 (hit): busywait stays 0; next read of 0x06 returns 0xAA; dirty set.
- Read 0x25 (same index 1, tag 1): WRITE_BACK with mem_address=0x01 and mem_writedata=0x44AA2211, then FETCH with mem_address=0x09; the CPU stalls through both.
- Write 0x5C to miss address 0x80 on a clean line: fetch of block 0x20, then the byte is written, dirty set, busywait falls.
- Assert reset during FETCH: mem_read=0 and busywait=0 immediately; all lines invalid; a following read of 0x05 misses again.
